// File: rtl/tile_board_pkg.sv
// Shared board types for the tile path animator.
//   TILE_IDX_W   : width of a tile index (board of up to 32 tiles)
//   COORD_W      : width of a pixel coordinate (0..1023)
//   tile_idx_t   : tile index type
//   coord_t      : pixel coordinate type
//   anim_state_e : walk FSM state encoding (ST_IDLE/ST_LOAD/ST_WALK/ST_DONE)
package tile_board_pkg;

    localparam int TILE_IDX_W = 5;
    localparam int COORD_W    = 10;

    typedef logic [TILE_IDX_W-1:0] tile_idx_t;
    typedef logic [COORD_W-1:0]    coord_t;

    typedef logic [1:0] anim_state_e;
    localparam anim_state_e ST_IDLE = 2'd0;
    localparam anim_state_e ST_LOAD = 2'd1;
    localparam anim_state_e ST_WALK = 2'd2;
    localparam anim_state_e ST_DONE = 2'd3;

endpackage

// File: rtl/tile_coord_calc.sv
// Combinational tile-index to pixel-coordinate mapping for one player.
// The board is serpentine: even rows run left-to-right, odd rows
// right-to-left. Rows advance downward; each player gets a fixed extra
// y offset so pieces sharing a tile stay visible.
//   tile : tile index of this player
//   x    : pixel x of the tile's column
//   y    : pixel y of the tile's row plus the player offset
module tile_coord_calc
    import tile_board_pkg::*;
#(
    parameter int COLS      = 10,
    parameter int TILE_W    = 60,
    parameter int TILE_H    = 60,
    parameter int X0        = 20,
    parameter int Y0        = 120,
    parameter int PLAYER_DY = 20,
    parameter int PLAYER    = 0
) (
    input  tile_idx_t tile,
    output coord_t    x,
    output coord_t    y
);

    int row;
    int c;
    int col;

    always_comb begin
        row = int'(tile) / COLS;
        c   = int'(tile) % COLS;
        // Odd rows are walked backwards, so mirror the column.
        col = row[0] ? (COLS - 1 - c) : c;
        x   = coord_t'(X0 + col * TILE_W);
        y   = coord_t'(Y0 + row * TILE_H + PLAYER * PLAYER_DY);
    end

endmodule

// File: rtl/tile_path_animator.sv
// Owns every player's board position and animates dice moves one tile at
// a time, one tile per STEP_TICKS frame ticks.
//   clk, reset   : clock, asynchronous active-high reset
//   tick         : one-cycle frame pulse pacing the walk
//   move_valid/move_ready/move_player/move_steps : move request handshake;
//                  a move is accepted on a cycle where move_valid and
//                  move_ready are both high, and its fields are sampled only
//                  then. move_ready is high only while idle; requests made
//                  while busy are dropped, not queued.
//   busy         : walk in progress (LOAD or WALK)
//   done         : one-cycle pulse when a move completes
//   tile/at_goal : per-player tile index and goal flag (state registers)
//   x/y          : per-player registered pixel coordinates
module tile_path_animator
    import tile_board_pkg::*;
#(
    parameter int NUM_TILES   = 20,
    parameter int COLS        = 10,
    parameter int NUM_PLAYERS = 2,
    parameter int TILE_W      = 60,
    parameter int TILE_H      = 60,
    parameter int X0          = 20,
    parameter int Y0          = 120,
    parameter int PLAYER_DY   = 20,
    parameter int STEP_TICKS  = 8,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tick,
    input  logic                              move_valid,
    output logic                              move_ready,
    input  logic [PW-1:0]                     move_player,
    input  logic [2:0]                        move_steps,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_PLAYERS*TILE_IDX_W-1:0] tile,
    output logic [NUM_PLAYERS-1:0]            at_goal,
    output logic [NUM_PLAYERS*COORD_W-1:0]    x,
    output logic [NUM_PLAYERS*COORD_W-1:0]    y
);

    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam tile_idx_t    GOAL      = tile_idx_t'(NUM_TILES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

    anim_state_e   state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    rem_q, rem_d;
    logic [PW-1:0] player_q, player_d;
    logic [2:0]    steps_q, steps_d;
    tile_idx_t     tile_q [NUM_PLAYERS];
    tile_idx_t     tile_d [NUM_PLAYERS];
    coord_t        x_q    [NUM_PLAYERS];
    coord_t        x_d    [NUM_PLAYERS];
    coord_t        y_q    [NUM_PLAYERS];
    coord_t        y_d    [NUM_PLAYERS];

    logic      accept;
    logic      player_ok;
    tile_idx_t cur_tile;
    tile_idx_t room;

    // Tile of the latched player and remaining room before the goal.
    // An out-of-range player index selects nothing and is rejected in LOAD.
    always_comb begin
        accept    = move_valid && (state_q == ST_IDLE);
        player_ok = int'(player_q) < NUM_PLAYERS;
        cur_tile  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (int'(player_q) == p) cur_tile = tile_q[p];
        end
        room = GOAL - cur_tile;
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        rem_d      = rem_q;
        player_d   = player_q;
        steps_d    = steps_q;
        tile_d     = tile_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    player_d = move_player;
                    steps_d  = move_steps;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tick_cnt_d = '0;
                // Clamp to the goal: excess steps are simply dropped.
                if (!player_ok) begin
                    rem_d = 3'd0;
                end else if ({{(TILE_IDX_W-3){1'b0}}, steps_q} <= room) begin
                    rem_d = steps_q;
                end else begin
                    rem_d = room[2:0];
                end
                state_d = (rem_d == 3'd0) ? ST_DONE : ST_WALK;
            end
            ST_WALK: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        rem_d      = rem_q - 3'd1;
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            if (int'(player_q) == p) tile_d[p] = tile_q[p] + tile_idx_t'(1);
                        end
                        if (rem_q == 3'd1) state_d = ST_DONE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            rem_q      <= '0;
            player_q   <= '0;
            steps_q    <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                tile_q[p] <= '0;
                x_q[p]    <= coord_t'(X0);
                y_q[p]    <= coord_t'(Y0 + p * PLAYER_DY);
            end
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            rem_q      <= rem_d;
            player_q   <= player_d;
            steps_q    <= steps_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                tile_q[p] <= tile_d[p];
                x_q[p]    <= x_d[p];
                y_q[p]    <= y_d[p];
            end
        end
    end

    assign move_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_WALK);
    assign done       = (state_q == ST_DONE);

    for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
        tile_coord_calc #(
            .COLS      (COLS),
            .TILE_W    (TILE_W),
            .TILE_H    (TILE_H),
            .X0        (X0),
            .Y0        (Y0),
            .PLAYER_DY (PLAYER_DY),
            .PLAYER    (gp)
        ) u_calc (
            .tile (tile_q[gp]),
            .x    (x_d[gp]),
            .y    (y_d[gp])
        );
        assign tile[gp*TILE_IDX_W +: TILE_IDX_W] = tile_q[gp];
        assign at_goal[gp]                       = (tile_q[gp] == GOAL);
        assign x[gp*COORD_W +: COORD_W]          = x_q[gp];
        assign y[gp*COORD_W +: COORD_W]          = y_q[gp];
    end

endmodule

// File: tb/tb_tile_path_animator.sv
// Directed bench for tile_path_animator: default two-player instance plus a
// three-player instance for the out-of-range player index case.
module tb_tile_path_animator;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick = 1'b0;
    logic        move_valid;
    logic        move_ready;
    logic [0:0]  move_player;
    logic [2:0]  move_steps;
    logic        busy;
    logic        done;
    logic [9:0]  tile;
    logic [1:0]  at_goal;
    logic [19:0] x;
    logic [19:0] y;

    logic        m3_valid;
    logic        m3_ready;
    logic [1:0]  m3_player;
    logic [2:0]  m3_steps;
    logic        b3;
    logic        d3;
    logic [14:0] tile3;
    logic [2:0]  ag3;
    logic [29:0] x3;
    logic [29:0] y3;

    int n_pass  = 0;
    int n_total = 0;
    logic [4:0] exp_q[$];
    int model_tile[2];

    tile_path_animator dut (
        .clk(clk), .reset(reset), .tick(tick),
        .move_valid(move_valid), .move_ready(move_ready),
        .move_player(move_player), .move_steps(move_steps),
        .busy(busy), .done(done), .tile(tile), .at_goal(at_goal),
        .x(x), .y(y)
    );

    tile_path_animator #(.NUM_PLAYERS(3)) dut3 (
        .clk(clk), .reset(reset), .tick(tick),
        .move_valid(m3_valid), .move_ready(m3_ready),
        .move_player(m3_player), .move_steps(m3_steps),
        .busy(b3), .done(d3), .tile(tile3), .at_goal(ag3),
        .x(x3), .y(y3)
    );

    // clock / reset / tick
    always #5 clk = ~clk;

    initial begin : tick_gen
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c++;
            tick = (c % 4 == 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Serpentine mapping of the board for the default parameters.
    function automatic logic [31:0] exp_x(input int t);
        int row, c, col;
        row = t / 10;
        c   = t % 10;
        col = (row % 2 == 1) ? 9 - c : c;
        return 32'(20 + col * 60);
    endfunction

    function automatic logic [31:0] exp_y(input int t, input int p);
        return 32'(120 + (t / 10) * 60 + p * 20);
    endfunction

    // driver tasks
    task automatic do_move(input int p, input int s);
        int w;
        w = 0;
        while (!move_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_move", move_ready, 1);
        move_valid  = 1'b1;
        move_player = p[0:0];
        move_steps  = s[2:0];
        @(negedge clk);
        move_valid = 1'b0;
        check("busy_in_load", busy, 1);
    endtask

    task automatic run_move(input int p, input int s, input bit poke);
        int start, n, wt, cyc, done_cnt, q;
        bit chk_xy;
        logic [4:0] cur, prev;
        q     = 1 - p;
        start = model_tile[p];
        n     = (s < 19 - start) ? s : 19 - start;
        for (int k = 1; k <= n; k++) exp_q.push_back(5'(start + k));
        do_move(p, s);
        wt = 0;
        done_cnt = 0;
        chk_xy = 1'b0;
        prev = tile[p*5 +: 5];
        for (cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
            @(negedge clk);
            if (chk_xy) begin
                check("x_step", x[p*10 +: 10], exp_x(int'(prev)));
                check("y_step", y[p*10 +: 10], exp_y(int'(prev), p));
                chk_xy = 1'b0;
            end
            cur = tile[p*5 +: 5];
            if (cur !== prev) begin
                if (exp_q.size() == 0) check("tile_extra_step", cur, prev);
                else check("tile_step", cur, exp_q.pop_front());
                check("step_tick_spacing", wt, 8 * (int'(cur) - start));
                prev = cur;
                chk_xy = 1'b1;
            end
            if (poke && cyc == 10) begin
                check("ready_low_while_busy", move_ready, 0);
                move_valid  = 1'b1;
                move_player = q[0:0];
                move_steps  = 3'd7;
            end else begin
                move_valid = 1'b0;
            end
            if (done) done_cnt++;
            else if (busy && tick) wt++;
        end
        move_valid = 1'b0;
        check("done_seen", done_cnt, 1);
        check("walk_ticks_total", wt, 8 * n);
        check("exp_q_empty", exp_q.size(), 0);
        if (n == 0) check("zero_move_latency", cyc, 1);
        exp_q.delete();
        model_tile[p] = start + n;
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("idle_after_done", move_ready, 1);
        check("tile_final", tile[p*5 +: 5], model_tile[p]);
        check("x_final", x[p*10 +: 10], exp_x(model_tile[p]));
        check("y_final", y[p*10 +: 10], exp_y(model_tile[p], p));
        check("other_tile_untouched", tile[q*5 +: 5], model_tile[q]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tile"}, tile, 0);
        check({tag, "_x0"}, x[9:0], 20);
        check({tag, "_y0"}, y[9:0], 120);
        check({tag, "_x1"}, x[19:10], 20);
        check({tag, "_y1"}, y[19:10], 140);
        check({tag, "_ready"}, move_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_at_goal"}, at_goal, 0);
    endtask

    initial begin
        int dcnt;
        reset       = 1'b1;
        move_valid  = 1'b0;
        move_player = '0;
        move_steps  = '0;
        m3_valid    = 1'b0;
        m3_player   = '0;
        m3_steps    = '0;
        model_tile[0] = 0;
        model_tile[1] = 0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check_reset_state("rst_held");
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("rst_released");

        // 2: p0 walks three tiles
        run_move(0, 3, 1'b0);
        check("t2_x", x[9:0], 200);
        check("t2_y", y[9:0], 120);

        // 3: p1 to tile 8, then across the row wrap
        run_move(1, 7, 1'b0);
        run_move(1, 1, 1'b0);
        check("t3_start_tile", tile[9:5], 8);
        check("t3_start_x", x[19:10], 500);
        run_move(1, 3, 1'b0);
        check("t3_x", x[19:10], 500);
        check("t3_y", y[19:10], 200);

        // 4: p0 to 17 (ignored request while busy), then clamp at goal
        run_move(0, 7, 1'b0);
        run_move(0, 7, 1'b1);
        check("t4_start_tile", tile[4:0], 17);
        run_move(0, 6, 1'b0);
        check("t4_tile", tile[4:0], 19);
        check("t4_at_goal", at_goal, 2'b01);
        check("t4_x", x[9:0], 20);
        check("t4_y", y[9:0], 180);

        // 5: zero-step moves and a move from the goal
        run_move(1, 0, 1'b0);
        run_move(0, 5, 1'b0);
        check("t5_goal_kept", tile[4:0], 19);

        // 5b: out-of-range player on the three-player instance
        @(negedge clk);
        m3_valid  = 1'b1;
        m3_player = 2'd3;
        m3_steps  = 3'd5;
        @(negedge clk);
        m3_valid = 1'b0;
        check("p3_busy_load", b3, 1);
        @(negedge clk);
        check("p3_done", d3, 1);
        @(negedge clk);
        check("p3_done_single", d3, 0);
        check("p3_tiles_unchanged", tile3, 0);
        check("p3_ready", m3_ready, 1);
        m3_valid  = 1'b1;
        m3_player = 2'd2;
        m3_steps  = 3'd1;
        @(negedge clk);
        m3_valid = 1'b0;
        for (int i = 0; i < 100 && !d3; i++) @(negedge clk);
        check("p2_done", d3, 1);
        @(negedge clk);
        check("p2_tile", tile3, 15'd1 << 10);
        check("p2_x", x3[29:20], 80);
        check("p2_y", y3[29:20], 160);

        // 6: reset in the middle of a walk
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_tile[0] = 0;
        model_tile[1] = 0;
        @(negedge clk);
        run_move(0, 5, 1'b0);
        do_move(0, 3);
        repeat (40) @(negedge clk);
        check("t6_moved_before_reset", tile[4:0], 6);
        reset = 1'b1;
        #1;
        check_reset_state("rst_mid_walk");
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("t6_no_done", dcnt, 0);
        check_reset_state("rst_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
